serial_sub: RTL and testbench

Bit-serial unsigned subtractor that computes `a - b` one bit per clock, LSB first. It sits directly downstream of the combinational half-subtractor cell. Two half-subtractor cells plus an OR form a full-subtractor bit cell, and a borrow flip-flop carries the borrow between cycles. It is the area-cheap alternative to a ripple subtractor for wide operands. Results are returned with a start/done handshake.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/half_sub.sv | 18 +
 rtl/serial_sub_full_sub_bit.sv | 40 ++++
 rtl/serial_sub.sv | 117 +++++++++++
 tb/tb_serial_sub.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared types for the bit-serial subtractor.
//   sub_state_t : controller states (IDLE, SHIFT, DONE)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

endpackage

// File: rtl/half_sub.sv
// half_sub
//   Combinational half-subtractor cell: d = a - b for single bits.
//   Ports:
//     a      in  1 : minuend bit
//     b      in  1 : subtrahend bit
//     d      out 1 : difference bit (a ^ b)
//     borrow out 1 : borrow generated when a=0, b=1
module half_sub (
  input  logic a,
  input  logic b,
  output logic d,
  output logic borrow
);

  assign d      = a ^ b;
  assign borrow = ~a & b;

endmodule

// File: rtl/serial_sub_full_sub_bit.sv
// full_sub_bit
//   One-bit full subtractor built from two half-subtractor cells.
//   The first cell subtracts b from a, the second subtracts the incoming
//   borrow from that partial difference; either stage can raise a borrow.
//   Ports:
//     a    in  1 : minuend bit
//     b    in  1 : subtrahend bit
//     bin  in  1 : borrow in from the previous (less significant) bit
//     d    out 1 : difference bit
//     bout out 1 : borrow out to the next bit
module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_borrow1;
  logic w_borrow2;

  half_sub u_hs1 (
    .a      (a),
    .b      (b),
    .d      (w_d1),
    .borrow (w_borrow1)
  );

  half_sub u_hs2 (
    .a      (w_d1),
    .b      (bin),
    .d      (d),
    .borrow (w_borrow2)
  );

  // The two borrows are mutually exclusive, so OR is the full borrow.
  assign bout = w_borrow1 | w_borrow2;

endmodule

// File: rtl/serial_sub.sv
// serial_sub
//   Bit-serial unsigned subtractor: computes a - b one bit per clock,
//   LSB first, with a start/done handshake.
//   Ports:
//     clk        in  1     : clock, rising edge
//     rst_n      in  1     : asynchronous active-low reset
//     start      in  1     : request a subtraction (honoured only in IDLE)
//     a          in  WIDTH : minuend, captured on the accepted start edge
//     b          in  WIDTH : subtrahend, captured on the accepted start edge
//     busy       out 1     : high while bits are being processed
//     done       out 1     : one-cycle pulse when diff/borrow_out are valid
//     diff       out WIDTH : (a - b) mod 2^WIDTH
//     borrow_out out 1     : 1 iff a < b (unsigned)
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_borrow;
  logic [CNTW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrowOut;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_dMsb;

  full_sub_bit u_bit (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  // New difference bit placed at the MSB; written this way so WIDTH=1
  // needs no zero-width slice of diff.
  always_comb begin
    w_dMsb            = '0;
    w_dMsb[WIDTH-1]   = w_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_borrow    <= 1'b0;
      r_cnt       <= '0;
      r_diff      <= '0;
      r_borrowOut <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sa     <= a;
            r_sb     <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_diff   <= (r_diff >> 1) | w_dMsb;
          r_sa     <= r_sa >> 1;
          r_sb     <= r_sb >> 1;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST_BIT) begin
            r_borrowOut <= w_bout;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrowOut;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub
//   Directed bench for serial_sub: an 8-bit instance driven from a vector
//   table plus hand-written sequences, and a 1-bit instance swept over all
//   operand pairs.
module tb_serial_sub;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expDiff;
    logic       expBorrow;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;

  logic       start1;
  logic       a1;
  logic       b1;
  logic       busy1;
  logic       done1;
  logic       diff1;
  logic       borrow1;

  int checks;
  int failures;

  serial_sub #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow1)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Run one 8-bit subtraction: start it, then wait (bounded) for done.
  // Returns the result and the number of edges from the start edge to done.
  // Ends after the DONE->IDLE edge so the next call is accepted directly.
  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib,
                               output logic [7:0] od, output logic ob,
                               output int lat);
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // operands may change after capture without affecting the run
    a = ~ia;
    b = ~ib;
    checkOutput("busyAfterStart", {31'b0, busy}, 32'd1);
    lat = 0;
    od = '0;
    ob = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        od = diff;
        ob = borrow_out;
        break;
      end
    end
    if (lat == 0) checkOutput("doneTimeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("donePulseWidth", {31'b0, done}, 32'd0);
    checkOutput("diffHold", {24'b0, diff}, {24'b0, od});
  endtask

  vec_t vecs[9];
  logic [7:0] gotD;
  logic       gotB;
  int         lat;
  int         doneCount;
  int         lastDone;
  int         cyc;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[5] = '{8'hC3, 8'h3C, 8'h87, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    vecs[7] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    vecs[8] = '{8'h00, 8'hFF, 8'h01, 1'b1};

    // Reset values
    #12;
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstDiff", {24'b0, diff}, 32'd0);
    checkOutput("rstBorrow", {31'b0, borrow_out}, 32'd0);
    checkOutput("rstDiff1", {31'b0, diff1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k].a, vecs[k].b, gotD, gotB, lat);
      checkOutput($sformatf("vecDiff%0d", k), {24'b0, gotD}, {24'b0, vecs[k].expDiff});
      checkOutput($sformatf("vecBorrow%0d", k), {31'b0, gotB}, {31'b0, vecs[k].expBorrow});
      checkOutput($sformatf("vecLatency%0d", k), lat, 32'd8);
    end

    // Start pulsed mid-run must be ignored and not queued
    @(negedge clk);
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    doneCount = 0;
    gotD = '0;
    gotB = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) begin
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (i == 3) start = 1'b0;
      if (done) begin
        doneCount++;
        gotD = diff;
        gotB = borrow_out;
      end
    end
    checkOutput("busyStartDoneCount", doneCount, 32'd1);
    checkOutput("busyStartDiff", {24'b0, gotD}, 32'h1E);
    checkOutput("busyStartBorrow", {31'b0, gotB}, 32'd0);
    checkOutput("busyStartIdle", {31'b0, busy}, 32'd0);

    // Reset mid-run: previous run left borrow_out=1 and partial diff is nonzero
    applyStimulus(8'h00, 8'h01, gotD, gotB, lat);
    @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
    checkOutput("midRstDone", {31'b0, done}, 32'd0);
    checkOutput("midRstDiff", {24'b0, diff}, 32'd0);
    checkOutput("midRstBorrow", {31'b0, borrow_out}, 32'd0);
    doneCount = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("midRstNoDone", doneCount, 32'd0);
    applyStimulus(8'h80, 8'h7F, gotD, gotB, lat);
    checkOutput("postRstDiff", {24'b0, gotD}, 32'h01);
    checkOutput("postRstBorrow", {31'b0, gotB}, 32'd0);

    // Start held high: a new run every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1;
    cyc = 0;
    lastDone = 0;
    for (int k = 0; k < 3; k++) begin
      a = vecs[k].a;
      b = vecs[k].b;
      lat = 0;
      for (int i = 1; i <= 30; i++) begin
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
          lat = cyc;
          break;
        end
      end
      if (lat == 0) checkOutput("b2bTimeout", 32'd0, 32'd1);
      checkOutput($sformatf("b2bDiff%0d", k), {24'b0, diff}, {24'b0, vecs[k].expDiff});
      checkOutput($sformatf("b2bBorrow%0d", k), {31'b0, borrow_out}, {31'b0, vecs[k].expBorrow});
      if (k > 0) checkOutput($sformatf("b2bInterval%0d", k), lat - lastDone, 32'd10);
      lastDone = lat;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("b2bIdle", {31'b0, busy}, 32'd0);

    // WIDTH=1: half-subtractor truth table
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      a1 = p[1];
      b1 = p[0];
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
        @(posedge clk);
        #1;
        if (done1) begin
          lat = i;
          break;
        end
      end
      checkOutput($sformatf("w1Latency%0d", p), lat, 32'd1);
      checkOutput($sformatf("w1Diff%0d", p), {31'b0, diff1}, {31'b0, p[1] ^ p[0]});
      checkOutput($sformatf("w1Borrow%0d", p), {31'b0, borrow1}, {31'b0, ~p[1] & p[0]});
      @(posedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
